// File: rtl/time_pkg.sv
// -----------------------------------------------------------------------------
// time_pkg
// Shared definitions for the ring-generator sequencer time_ctrl:
//   - state_e        : controller state encoding
//   - beat_e         : identity of a single ring beat (t1/t2/t3)
//   - next_beat()    : successor of a beat in the t1->t2->t3->t1 ring
//   - TIME_CNT_W_DEF / TIME_LAUNCH_TO_DEF : default parameter values
// -----------------------------------------------------------------------------
package time_pkg;

    localparam int TIME_CNT_W_DEF     = 4;
    localparam int TIME_LAUNCH_TO_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_FINISH = 3'd3,
        S_ERR    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        B_T1 = 2'd0,
        B_T2 = 2'd1,
        B_T3 = 2'd2
    } beat_e;

    function automatic beat_e next_beat(input beat_e b);
        case (b)
            B_T1:    return B_T2;
            B_T2:    return B_T3;
            default: return B_T1;
        endcase
    endfunction

endpackage

// File: rtl/time_chk.sv
// -----------------------------------------------------------------------------
// time_chk
// Watches the three ring beat inputs and flags protocol violations.
// It always tracks the last single beat seen, so when the controller
// enters RUN on a clean t1 the expected successor is already t2.
//
// Ports
//   i_clk    : clock
//   i_rst    : synchronous active-high reset
//   i_t1..3  : ring beat pulses from the timing generator
//   o_multi  : more than one beat high this cycle
//   o_none   : no beat high this cycle
//   o_order  : a single beat is high but it is not the successor of the
//              previously seen beat
// -----------------------------------------------------------------------------
module time_chk
    import time_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_t1,
    input  logic i_t2,
    input  logic i_t3,
    output logic o_multi,
    output logic o_none,
    output logic o_order
);

    beat_e r_last;
    beat_e w_beat;
    logic  w_one;

    assign o_multi = (i_t1 & i_t2) | (i_t1 & i_t3) | (i_t2 & i_t3);
    assign o_none  = ~(i_t1 | i_t2 | i_t3);
    assign w_one   = ~o_multi & ~o_none;

    always_comb begin
        w_beat = B_T1;
        if (i_t2)
            w_beat = B_T2;
        else if (i_t3)
            w_beat = B_T3;
    end

    assign o_order = w_one && (w_beat != next_beat(r_last));

    // Reset to t3 so the first legal beat after reset is t1.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_last <= B_T3;
        else if (w_one)
            r_last <= w_beat;
    end

endmodule

// File: rtl/time_ctrl.sv
// -----------------------------------------------------------------------------
// time_ctrl
// Sequencer for a three-phase ring timing generator. On a request it starts
// the generator (nSTART low), counts t3 beats, drops nSTOP during the final t3
// so the generator halts cleanly after ncyc full cycles, then pulses done.
// Any protocol violation or a missing first t1 parks the block in ERR with the
// generator held stopped until reset.
//
// Optional feature macro: TIME_CTRL_ABORT_EN
//   When defined, adds input 'abort'; abort in RUN ends the run at the next
//   t3 that can be reached with nSTOP already low.
//
// Parameters
//   CNT_W     : width of ncyc / beats
//   LAUNCH_TO : clocks allowed in LAUNCH before t1 must appear
//
// Ports
//   CLK     : clock, rising edge
//   Rst     : synchronous active-high reset, highest priority
//   req     : run request, sampled in IDLE
//   ncyc    : number of full t1-t2-t3 cycles, sampled with req
//   t1..t3  : ring beats from the generator
//   abort   : (TIME_CTRL_ABORT_EN only) early end request
//   nSTART  : generator start, active low, registered
//   nSTOP   : generator stop, active low, registered
//   busy    : not in IDLE
//   done    : one-clock pulse at the end of a run
//   err     : sticky error flag
//   beats   : t3 pulses seen in the current or last run
//
// State table
//   IDLE   | waiting for req with non-zero ncyc
//   LAUNCH | nSTART low, waiting (bounded) for the first clean t1
//   RUN    | counting beats, checking order, scheduling nSTOP
//   FINISH | run complete, generator must be quiet for one clock
//   ERR    | fault; nSTART high, nSTOP low, leaves only on Rst
// -----------------------------------------------------------------------------
module time_ctrl
    import time_pkg::*;
#(
    parameter int CNT_W     = TIME_CNT_W_DEF,
    parameter int LAUNCH_TO = TIME_LAUNCH_TO_DEF
) (
    input  logic             CLK,
    input  logic             Rst,
    input  logic             req,
    input  logic [CNT_W-1:0] ncyc,
    input  logic             t1,
    input  logic             t2,
    input  logic             t3,
`ifdef TIME_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             nSTART,
    output logic             nSTOP,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] beats
);

    localparam int TMR_W = (LAUNCH_TO > 1) ? $clog2(LAUNCH_TO) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LAUNCH_TO - 1);

    state_e           r_state;
    logic             r_nstart;
    logic             r_nstop;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] r_beats;
    logic [CNT_W-1:0] r_ncyc;
    logic [TMR_W-1:0] r_tmr;

    logic             w_multi;
    logic             w_none;
    logic             w_order;
    logic             w_fault;
    logic             w_abort_t2;
    logic             w_abort_t3;
    logic [CNT_W-1:0] w_last_beat;

    time_chk u_chk (
        .i_clk   (CLK),
        .i_rst   (Rst),
        .i_t1    (t1),
        .i_t2    (t2),
        .i_t3    (t3),
        .o_multi (w_multi),
        .o_none  (w_none),
        .o_order (w_order)
    );

`ifdef TIME_CTRL_ABORT_EN
    // An abort seen on t1 is remembered so the following t2 still stops the run.
    logic r_abort_pend;

    always_ff @(posedge CLK) begin
        if (Rst || (r_state != S_RUN))
            r_abort_pend <= 1'b0;
        else if (abort)
            r_abort_pend <= 1'b1;
    end

    assign w_abort_t2 = abort | r_abort_pend;
    assign w_abort_t3 = abort;
`else
    assign w_abort_t2 = 1'b0;
    assign w_abort_t3 = 1'b0;
`endif

    // Beat count at the t2 of the final cycle.
    assign w_last_beat = r_ncyc - CNT_W'(1);

    always_comb begin
        w_fault = 1'b0;
        case (r_state)
            S_IDLE:   w_fault = 1'b0;
            S_LAUNCH: w_fault = w_multi | (~t1 & (r_tmr == '0));
            S_RUN:    w_fault = w_multi | w_none | w_order;
            S_FINISH: w_fault = t1 | t2 | t3;
            default:  w_fault = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            r_state  <= S_IDLE;
            r_nstart <= 1'b1;
            r_nstop  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_beats  <= '0;
            r_ncyc   <= '0;
            r_tmr    <= '0;
        end else if (w_fault) begin
            // Also re-asserts the ERR outputs every clock while parked.
            r_state  <= S_ERR;
            r_nstart <= 1'b1;
            r_nstop  <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req && (ncyc != '0)) begin
                        r_ncyc   <= ncyc;
                        r_beats  <= '0;
                        r_nstart <= 1'b0;
                        r_tmr    <= TMR_LOAD;
                        r_busy   <= 1'b1;
                        r_state  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (t1)
                        r_state <= S_RUN;
                    else
                        r_tmr <= r_tmr - TMR_W'(1);
                end
                S_RUN: begin
                    if (t3) begin
                        if (r_beats != '1)
                            r_beats <= r_beats + CNT_W'(1);
                        if (!r_nstop) begin
                            r_nstart <= 1'b1;
                            r_nstop  <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= S_FINISH;
                        end else if (w_abort_t3) begin
                            r_nstop <= 1'b0;
                        end
                    end else if (t2 && ((r_beats == w_last_beat) || w_abort_t2)) begin
                        // Registered here so nSTOP is low for exactly the final t3.
                        r_nstop <= 1'b0;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign nSTART = r_nstart;
    assign nSTOP  = r_nstop;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign beats  = r_beats;

endmodule
